// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared constants and entry type for the instruction fetch queue
package ifq_pkg;

  localparam int IFQ_DEPTH  = 8;
  localparam int IFQ_ADDR_W = 32;
  localparam int IFQ_PTR_W  = $clog2(IFQ_DEPTH);
  localparam int IFQ_CNT_W  = IFQ_PTR_W + 1;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]           inst;
    logic [IFQ_ADDR_W-1:0] addr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - entry array with two consecutive write ports and two read ports
module ifq_storage #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] wr_idx0,
  input  logic [$clog2(DEPTH)-1:0] wr_idx1,
  input  logic [W-1:0]             wr_data0,
  input  logic [W-1:0]             wr_data1,
  input  logic [$clog2(DEPTH)-1:0] rd_idx0,
  input  logic [$clog2(DEPTH)-1:0] rd_idx1,
  output logic [W-1:0]             rd_data0,
  output logic [W-1:0]             rd_data1
);

  logic [W-1:0] mem [DEPTH];

  // Contents need no reset: the top gates every read with its valid count.
  always_ff @(posedge clk) begin
    if (we0) mem[wr_idx0] <= wr_data0;
    if (we1) mem[wr_idx1] <= wr_data1;
  end

  assign rd_data0 = mem[rd_idx0];
  assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/ifq_fetch_queue.sv
// rtl/ifq_fetch_queue.sv - dual-issue instruction fetch queue; IFQ_BYPASS_EN enables empty-queue bypass
module ifq_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int ADDR_W = IFQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              fetchValid_i,
  output logic              fetchReady_o,
  input  logic [ADDR_W-1:0] fetchAddr_i,
  input  logic [63:0]       fetchData_i,
  output logic              way0Valid_o,
  output logic [31:0]       way0Inst_o,
  output logic [ADDR_W-1:0] way0Addr_o,
  output logic              way1Valid_o,
  output logic [31:0]       way1Inst_o,
  output logic [ADDR_W-1:0] way1Addr_o,
  input  logic [1:0]        issueCount_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = 32 + ADDR_W;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             enq, single, bypass;
  logic [1:0]       n_in, avail, deq;
  logic [EW-1:0]    in0, in1, st0, st1, e0, e1;

  assign fetchReady_o = (count <= CNT_W'(DEPTH - 2));
  assign enq          = fetchValid_i & fetchReady_o & ~flush_i;
  assign single       = fetchAddr_i[2];
  assign n_in         = single ? 2'd1 : 2'd2;

  // An upper-slot packet carries only its high word, at the packet PC itself.
  assign in0 = single ? {fetchData_i[63:32], fetchAddr_i} : {fetchData_i[31:0], fetchAddr_i};
  assign in1 = {fetchData_i[63:32], fetchAddr_i + ADDR_W'(4)};

`ifdef IFQ_BYPASS_EN
  assign bypass = enq & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Issue beyond the visible ways saturates; a flush cancels it outright.
  assign avail = bypass ? n_in : ((count > CNT_W'(1)) ? 2'd2 : count[1:0]);
  assign deq   = flush_i ? 2'd0 : ((issueCount_i > avail) ? avail : issueCount_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + (enq ? PTR_W'(n_in) : '0);
      rd_ptr <= rd_ptr + PTR_W'(deq);
      count  <= count + (enq ? CNT_W'(n_in) : '0) - CNT_W'(deq);
    end
  end

  ifq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
    .clk      (clk),
    .we0      (enq),
    .we1      (enq & ~single),
    .wr_idx0  (wr_ptr),
    .wr_idx1  (wr_ptr + PTR_W'(1)),
    .wr_data0 (in0),
    .wr_data1 (in1),
    .rd_idx0  (rd_ptr),
    .rd_idx1  (rd_ptr + PTR_W'(1)),
    .rd_data0 (st0),
    .rd_data1 (st1)
  );

  assign e0 = bypass ? in0 : st0;
  assign e1 = bypass ? in1 : st1;

  always_comb begin
    way0Valid_o = bypass | (count != '0);
    way1Valid_o = bypass ? ~single : (count > CNT_W'(1));
    way0Inst_o  = way0Valid_o ? e0[EW-1:ADDR_W] : NOP_INST;
    way0Addr_o  = way0Valid_o ? e0[ADDR_W-1:0] : '0;
    way1Inst_o  = way1Valid_o ? e1[EW-1:ADDR_W] : NOP_INST;
    way1Addr_o  = way1Valid_o ? e1[ADDR_W-1:0] : '0;
  end

endmodule

// File: doc/ifq_fetch_queue.md
Name: ifq_fetch_queue

Overview:
Instruction fetch queue that feeds the dual-issue decode stage: the transmit side of the instruction/address interface the way0/way1 decoders consume. Accepts 64-bit aligned fetch packets of two RV64 instructions from the fetch unit and buffers them in program order. Presents the two oldest instructions (inst + PC) to way0/way1 every cycle. Decode retires 0, 1 or 2 of them per cycle; a redirect flush empties the queue.

Parameters:
DEPTH, 8, number of 32-bit instruction entries; power of two, >= 4
ADDR_W, 32, instruction address width

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
flush_i  input  1  redirect/flush from branch resolution; empties queue
fetchValid_i  input  1  fetch packet valid
fetchReady_o  output  1  queue can take a full packet
fetchAddr_i  input  ADDR_W  packet PC; bit[1:0]=0, bit[2] selects start slot
fetchData_i  input  64  [31:0] = inst at PC&~7, [63:32] = inst at (PC&~7)+4
way0Valid_o  output  1  way0 holds oldest instruction
way0Inst_o  output  32  oldest instruction
way0Addr_o  output  ADDR_W  PC of way0Inst_o
way1Valid_o  output  1  way1 holds second-oldest instruction
way1Inst_o  output  32  second-oldest instruction
way1Addr_o  output  ADDR_W  PC of way1Inst_o
issueCount_i  input  2  instructions consumed by decode this cycle (0,1,2)

Behaviour:
- Reset: rd/wr pointers 0, count 0; fetchReady_o=1; wayNValid_o=0, wayNInst_o=32'h0000_0013 (NOP), wayNAddr_o=0. Async assert, sync-safe deassert behaviour is the reset synchroniser's concern.
- Storage: circular buffer of DEPTH {inst, addr} entries; wrPtr/rdPtr log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
- Enqueue: handshake = fetchValid_i & fetchReady_o & ~flush_i. fetchAddr_i[2]=0 -> 2 entries (PC, PC+4); =1 -> 1 entry (upper word only, PC).
- fetchReady_o = (DEPTH - count) >= 2, from registered count only; does not depend on issueCount_i (no combinational ready path).
- Dequeue: rdPtr += issueCount_i, count -= issueCount_i. issueCount_i greater than the number of valid ways is illegal; the design saturates at the valid count (bench asserts it never happens).
- Simultaneous enqueue and dequeue: count_next = count + enq - deq; both occur in the same cycle, including when full-ready boundary is reached.
- Outputs (no bypass): way0 = entry[rdPtr], way1 = entry[rdPtr+1 mod DEPTH]; way0Valid_o = count>=1, way1Valid_o = count>=2. Enqueue-to-visible latency 1 cycle. Invalid way drives NOP and addr 0.
- Flush: priority over everything; next cycle count=0, pointers reset to 0, same-cycle fetch and issue ignored; fetchReady_o=1 the cycle after.
- Reset mid-operation: all state cleared immediately (async), identical to reset values.

Optional Feature:
IFQ_BYPASS_EN: when defined, if count==0 and an enqueue handshake occurs, the incoming instruction(s) drive way0/way1 combinationally the same cycle (zero latency); decode may issue them that cycle and only un-issued ones are written. Without it: registered-only path, 1-cycle latency, behaviour as above. Flush also kills bypassed outputs.

Decomposition:
- Package ifq_pkg: DEPTH default, NOP_INST = 32'h0000_0013, entry typedef {inst[31:0], addr[ADDR_W-1:0]}, pointer/count width constants.
- Sub-module ifq_storage: DEPTH-entry register array, 2 write ports (consecutive indices) and 2 read ports (rdPtr, rdPtr+1); pointer/count control stays in top.

Test Plan:
- Reset then idle -> fetchReady_o=1, both ways valid=0, inst=32'h00000013, addr=0.
- Packet addr 0x8000_0000, data {0x00A00593,0x00100513}, issue 0 -> next cycle way0=0x00100513@0x80000000, way1=0x00A00593@0x80000004, both valid.
- Packet addr 0x8000_0014 (bit2=1), data {0x00000073,xxx} -> only way0 valid, inst 0x00000073 @0x80000014.
- Fill with 4 packets (8 entries), issue 0 -> fetchReady_o=0 after 3rd packet if count==6? no: ready drops when count==7 or 8; with count=8, issue 2 plus fetch same cycle -> count stays 8 only if ready was high, else 6; check wrap of pointers after 3 rounds.
- Queue holding 5, flush_i=1 with fetchValid_i=1 and issueCount_i=2 -> next cycle count=0, both valid=0, fetched packet dropped.
- IFQ_BYPASS_EN: empty queue, packet 0x8000_0100 arrives with issueCount_i=1 -> way0 valid same cycle, next cycle way0=inst @0x80000104 and count=1.
